alu_result_display: RTL and testbench

- Downstream stage of the ALU datapath. Captures the 8-bit ALU answer on request.
- Converts the captured value to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a 4-digit, time-multiplexed, common-anode seven-segment display with the decimal result.
- Gives the board a human-readable view of the ALU result.

---
 rtl/alu_result_display.sv | 139 +++++++++++++
 tb/tb_alu_result_display.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// Captures an ALU answer, converts it to BCD with a double-dabble engine, and scans it onto a
// 4-digit common-anode seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module alu_result_display #(
    parameter int NUM_WIDTH   = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WIDTH-1:0] answer_in,
    input  logic                 load,
    output logic                 busy,
    output logic                 valid,
    output logic [15:0]          bcd_out,
    output logic [6:0]           seg,
    output logic [3:0]           an
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [3:0]  LAST_BIT     = 4'(NUM_WIDTH);
    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

    state_t               state_reg;
    logic [NUM_WIDTH-1:0] bin_reg;
    logic [15:0]          scratch_reg;
    logic [3:0]           bit_cnt_reg;
    logic [15:0]          adjusted;
    logic [15:0]          refresh_cnt_reg;
    logic [1:0]           index_reg;
    logic [3:0]           digit;
    logic [3:0]           blank;

    // Add-3 correction for every nibble that would overflow past 9 on the next shift.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adjust
            logic [3:0] nib;
            assign nib = scratch_reg[gi*4 +: 4];
            assign adjusted[gi*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bin_reg     <= '0;
            scratch_reg <= '0;
            bit_cnt_reg <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            bcd_out     <= 16'h0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        bin_reg     <= answer_in;
                        scratch_reg <= '0;
                        bit_cnt_reg <= '0;
                        busy        <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // One extra visit after the last shift hands over to DONE.
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_reg <= DONE;
                    end else begin
                        {scratch_reg, bin_reg} <= {adjusted, bin_reg} << 1;
                        bit_cnt_reg            <= bit_cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    bcd_out   <= scratch_reg;
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark only when it and every more-significant digit are zero.
    assign blank[3] = (bcd_out[15:12] == 4'd0);
    assign blank[2] = blank[3] && (bcd_out[11:8] == 4'd0);
    assign blank[1] = blank[2] && (bcd_out[7:4] == 4'd0);
    assign blank[0] = 1'b0;
`else
    assign blank = 4'b0000;
`endif

    assign digit = bcd_out[{index_reg, 2'b00} +: 4];

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    // seg and an come from the same index on the same edge, so digits never ghost.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_reg <= '0;
            index_reg       <= '0;
            seg             <= 7'h7F;
            an              <= 4'hF;
        end else begin
            if (refresh_cnt_reg == REFRESH_LAST) begin
                refresh_cnt_reg <= '0;
                index_reg       <= index_reg + 2'd1;
            end else begin
                refresh_cnt_reg <= refresh_cnt_reg + 16'd1;
            end
            if (valid) begin
                an  <= ~(4'b0001 << index_reg);
                seg <= blank[index_reg] ? 7'h7F : decode(digit);
            end else begin
                an  <= 4'hF;
                seg <= 7'h7F;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display: conversions, latency, busy lockout, reset abort,
// display scan order and (when LEADING_ZERO_BLANK_EN is defined) leading-zero blanking.
module tb_alu_result_display;

    localparam int NW = 8;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NW-1:0] answer_in;
    logic          load;
    logic          busy;
    logic          valid;
    logic [15:0]   bcd_out;
    logic [6:0]    seg;
    logic [3:0]    an;

    int            errors = 0;
    int            checks = 0;
    logic [15:0]   sb[$];
    logic [15:0]   sb_exp;
    logic          busy_prev = 1'b0;

    alu_result_display #(.NUM_WIDTH(NW), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .reset    (reset),
        .answer_in(answer_in),
        .load     (load),
        .busy     (busy),
        .valid    (valid),
        .bcd_out  (bcd_out),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int v);
        bcd_of = 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int d);
        logic [6:0] tbl[10];
        int p;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        p = (d == 0) ? 1 : (d == 1) ? 10 : (d == 2) ? 100 : 1000;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && v < p) return 7'h7F;
`endif
        return tbl[(v / p) % 10];
    endfunction

    // Scoreboard: each completed conversion (busy falling) pops one expected value.
    always @(negedge clk) begin
        if (reset) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !busy) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    sb_exp = sb.pop_front();
                    $display("conversion: bcd_out=%04h expected=%04h", bcd_out, sb_exp);
                    check("sb_bcd", 32'(bcd_out), 32'(sb_exp));
                end
            end
            busy_prev = busy;
        end
    end

    // Load at edge 0; busy through edge NW+1, result at edge NW+2.
    task automatic convert(input int value);
        answer_in = NW'(value);
        load      = 1'b1;
        @(posedge clk); #1;
        load      = 1'b0;
        answer_in = NW'(~value);
        sb.push_back(bcd_of(value));
        check("busy_edge0", 32'(busy), 32'd1);
        for (int k = 1; k <= NW + 1; k++) begin
            @(posedge clk); #1;
            check("busy_during", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        check("busy_done", 32'(busy), 32'd0);
        check("valid_done", 32'(valid), 32'd1);
        check("bcd_done", 32'(bcd_out), 32'(bcd_of(value)));
    endtask

    task automatic check_digits(input int value);
        logic found;
        for (int d = 0; d < 4; d++) begin
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                @(posedge clk); #1;
                if (an == ~(4'b0001 << d)) found = 1'b1;
            end
            check("digit_found", 32'(found), 32'd1);
            check("digit_seg", 32'(seg), 32'(exp_seg(value, d)));
        end
    endtask

    task automatic check_refresh(input int value);
        logic [3:0] an_tbl[4];
        logic [3:0] prev;
        logic       found;
        int         start;
        int         d;
        an_tbl = '{4'hE, 4'hD, 4'hB, 4'h7};
        prev   = an;
        found  = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (an !== prev) found = 1'b1;
        end
        check("refresh_sync", 32'(found), 32'd1);
        start = 0;
        for (int s = 0; s < 4; s++) if (an == an_tbl[s]) start = s;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < RD; j++) begin
                if (i != 0 || j != 0) begin
                    @(posedge clk); #1;
                end
                d = (start + i) % 4;
                check("refresh_an", 32'(an), 32'(an_tbl[d]));
                check("refresh_seg", 32'(seg), 32'(exp_seg(value, d)));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        answer_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'h0000);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset during SHIFT cycle 4 of converting 200: result must be discarded.
        answer_in = NW'(200);
        load      = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_bcd_hold", 32'(bcd_out), 32'h0000);
        check("abort_valid", 32'(valid), 32'd0);

        convert(255);
        convert(0);
        convert(9);
        convert(10);
        convert(99);
        convert(128);

        // Busy lockout: second load with 7 two cycles later must be ignored.
        answer_in = NW'(100);
        load      = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        sb.push_back(bcd_of(100));
        @(posedge clk); #1;
        answer_in = NW'(7);
        load      = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        begin
            logic done;
            done = 1'b0;
            for (int c = 0; c < 30 && !done; c++) begin
                @(posedge clk); #1;
                if (!busy) done = 1'b1;
            end
            check("lockout_done", 32'(done), 32'd1);
        end
        check("lockout_bcd", 32'(bcd_out), 32'h0100);
        convert(7);

        check_digits(7);
        convert(0);
        check_digits(0);
        convert(255);
        check_refresh(255);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
